// File: rtl/clock_pkg.sv
// Shared types and constants for the alarm-clock time/alarm editor.
package clock_pkg;

  // One BCD time-of-day value: {H1,H0} in hour, {M1,M0} in min.
  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
  } bcd_hhmm_t;

  typedef enum logic [1:0] {
    StIdle,
    StEdit,
    StCommit
  } edit_state_t;

  localparam logic [7:0] HourMax = 8'h23;
  localparam logic [7:0] MinMax  = 8'h59;

endpackage

// File: rtl/bcd_step.sv
// Combinational BCD +1 on a two-digit field, wrapping at max_i.
// Any invalid digit or a value above max_i steps to 00.
module bcd_step (
  input  logic [7:0] value_i,
  input  logic [7:0] max_i,
  output logic [7:0] next_o
);

  logic invalid;

  // Wrap at the field maximum, carry the low digit into the high digit at 9.
  always_comb begin
    invalid = (value_i[7:4] > 4'd9) || (value_i[3:0] > 4'd9) || (value_i > max_i);
    if (invalid || (value_i == max_i)) begin
      next_o = 8'h00;
    end else if (value_i[3:0] == 4'd9) begin
      next_o = {value_i[7:4] + 4'd1, 4'd0};
    end else begin
      next_o = {value_i[7:4], value_i[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/bcd_time_editor.sv
// Time/alarm setting unit: holds NumAlarms BCD HH:MM alarms, edits the live
// time or one alarm through an IDLE/EDIT/COMMIT state machine, and drives
// the display word and the timekeeper load pulse.
module bcd_time_editor
  import clock_pkg::*;
#(
  parameter int unsigned NumAlarms   = 2,
  parameter int unsigned RepeatDelay = 2,
  parameter logic [15:0] AlarmReset  = 16'h0700
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick_half_i,
  input  logic [15:0]             time_in_i,
  input  logic [2:0]              sel_i,
  input  logic                    edit_en_i,
  input  logic                    commit_i,
  input  logic                    incr_hour_i,
  input  logic                    incr_minute_i,
  output logic [15:0]             disp_data_o,
  output logic [16*NumAlarms-1:0] alarm_data_o,
  output logic                    time_load_o,
  output logic [15:0]             time_load_data_o,
  output logic                    editing_o
);

  edit_state_t state_q, state_d;
  logic [2:0]  tgt_q, tgt_d;
  bcd_hhmm_t   work_q, work_d;
  logic [3:0]  rpt_q, rpt_d;
  logic        hour_prev_q, min_prev_q;
  logic [15:0] alarm_q [NumAlarms];
  logic [15:0] alarm_d [NumAlarms];
  logic [15:0] disp_q, disp_d;
  logic        load_q, load_d;
  logic [15:0] load_data_q, load_data_d;
  logic        editing_q, editing_d;

  logic [7:0]  hour_next, min_next;
  logic        btn_held, btn_rise, step;

  bcd_step u_step_hour (
    .value_i (work_q.hour),
    .max_i   (HourMax),
    .next_o  (hour_next)
  );

  bcd_step u_step_min (
    .value_i (work_q.min),
    .max_i   (MinMax),
    .next_o  (min_next)
  );

  // Button step source: minute wins when both are held; rise on edge, repeat on tick.
  always_comb begin
    btn_held = incr_minute_i | incr_hour_i;
    btn_rise = incr_minute_i ? ~min_prev_q : (incr_hour_i & ~hour_prev_q);
    // A rise coincident with a tick still yields a single step.
    step     = btn_rise | (btn_held & tick_half_i & (rpt_q == 4'(RepeatDelay)));
    if ((state_q != StEdit) || !btn_held || btn_rise) begin
      rpt_d = 4'd0;
    end else if (tick_half_i && (rpt_q < 4'(RepeatDelay))) begin
      rpt_d = rpt_q + 4'd1;
    end else begin
      rpt_d = rpt_q;
    end
  end

  // Edit state machine next-state, working register, alarm write-back and outputs.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    work_d      = work_q;
    alarm_d     = alarm_q;
    load_d      = 1'b0;
    load_data_d = load_data_q;
    unique case (state_q)
      StIdle: begin
        if (edit_en_i && (32'(sel_i) <= NumAlarms)) begin
          state_d = StEdit;
          tgt_d   = sel_i;
          work_d  = time_in_i;
          for (int unsigned k = 0; k < NumAlarms; k++) begin
            if (sel_i == 3'(k + 1)) work_d = alarm_q[k];
          end
        end
      end
      StEdit: begin
        if (commit_i) begin
          state_d = StCommit;
          if (tgt_q == 3'd0) begin
            load_d      = 1'b1;
            load_data_d = work_q;
          end
        end else if (!edit_en_i) begin
          state_d = StIdle;
        end else if (step) begin
          if (incr_minute_i) work_d.min = min_next;
          else               work_d.hour = hour_next;
        end
      end
      StCommit: begin
        state_d = StIdle;
        for (int unsigned k = 0; k < NumAlarms; k++) begin
          if (tgt_q == 3'(k + 1)) alarm_d[k] = work_q;
        end
      end
      default: state_d = StIdle;
    endcase
    disp_d    = (state_q == StIdle) ? time_in_i : work_q;
    editing_d = (state_d == StEdit);
  end

  // State and registered outputs; reset aborts any edit in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tgt_q       <= 3'd0;
      work_q      <= '0;
      rpt_q       <= 4'd0;
      hour_prev_q <= 1'b0;
      min_prev_q  <= 1'b0;
      disp_q      <= 16'h0000;
      load_q      <= 1'b0;
      load_data_q <= 16'h0000;
      editing_q   <= 1'b0;
      for (int unsigned k = 0; k < NumAlarms; k++) alarm_q[k] <= AlarmReset;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      work_q      <= work_d;
      rpt_q       <= rpt_d;
      hour_prev_q <= incr_hour_i;
      min_prev_q  <= incr_minute_i;
      disp_q      <= disp_d;
      load_q      <= load_d;
      load_data_q <= load_data_d;
      editing_q   <= editing_d;
      alarm_q     <= alarm_d;
    end
  end

  for (genvar k = 0; k < NumAlarms; k++) begin : g_alarm_out
    assign alarm_data_o[16*k +: 16] = alarm_q[k];
  end

  assign disp_data_o      = disp_q;
  assign time_load_o      = load_q;
  assign time_load_data_o = load_data_q;
  assign editing_o        = editing_q;

endmodule
